// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 keycode receiver.
// Build option: PS2_PARITY_CHECK_EN (used by ps2_keycode_receiver).
package ps2_pkg;

    // Receive FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
    localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;

    // One FIFO entry: prefix flags plus scan code
    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } key_event_t;

endpackage

// File: rtl/ps2_edge_filter.sv
// ps2_edge_filter: 2-FF synchronisers on PS/2 clock and data, a stability
// filter on the clock, and a one-cycle fall pulse on filtered 1->0.
module ps2_edge_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_ps2_clk,
    input  logic i_ps2_data,
    output logic o_fall,
    output logic o_data
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]    r_clk_sync;
    logic [1:0]    r_data_sync;
    logic          r_filt;
    logic [CW-1:0] r_cnt;
    logic          r_fall;

    // Synchronise both lines; idle level of the bus is high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
            r_data_sync <= {r_data_sync[0], i_ps2_data};
        end
    end

    // Filtered clock follows the synchronised clock only after it has
    // differed for FILTER_LEN consecutive cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_filt <= 1'b1;
            r_cnt  <= '0;
            r_fall <= 1'b0;
        end else begin
            r_fall <= 1'b0;
            if (r_clk_sync[1] != r_filt) begin
                if (r_cnt == CW'(FILTER_LEN - 1)) begin
                    r_filt <= r_clk_sync[1];
                    r_fall <= r_filt;
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_fall = r_fall;
    assign o_data = r_data_sync[1];

endmodule

// File: rtl/ps2_keycode_receiver.sv
// ps2_keycode_receiver: PS/2 frame receiver with E0/F0 prefix folding and
// a key-event FIFO. Build option: PS2_PARITY_CHECK_EN enables odd-parity
// checking; without it only start and stop bits are checked.
module ps2_keycode_receiver
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_release,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       err_frame,
    output logic       err_timeout,
    output logic       err_overflow
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    logic w_fall;
    logic w_data;
    logic w_frame_ok;

    ps2_state_t     r_state;
    logic [2:0]     r_bitcnt;
    logic [7:0]     r_shift;
    logic [WDW-1:0] r_wd;
    logic           r_ext;
    logic           r_brk;
    logic           r_push;
    key_event_t     r_push_evt;
    logic           r_err_frame;
    logic           r_err_timeout;
    logic           r_err_overflow;
`ifdef PS2_PARITY_CHECK_EN
    logic           r_parity;
`endif

    key_event_t r_mem [FIFO_DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic        w_empty;
    logic        w_full;
    logic        w_pop;
    logic        w_wr;
    key_event_t  w_head;

    ps2_edge_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filt (
        .clk        (clk),
        .rst        (rst),
        .i_ps2_clk  (ps2_clk),
        .i_ps2_data (ps2_data),
        .o_fall     (w_fall),
        .o_data     (w_data)
    );

`ifdef PS2_PARITY_CHECK_EN
    assign w_frame_ok = w_data && (^{r_parity, r_shift});
`else
    assign w_frame_ok = w_data;
`endif

    // Frame FSM, watchdog, prefix flags and the registered push request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_bitcnt      <= '0;
            r_shift       <= '0;
            r_wd          <= '0;
            r_ext         <= 1'b0;
            r_brk         <= 1'b0;
            r_push        <= 1'b0;
            r_push_evt    <= '0;
            r_err_frame   <= 1'b0;
            r_err_timeout <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            r_parity      <= 1'b0;
`endif
        end else begin
            r_push        <= 1'b0;
            r_err_frame   <= 1'b0;
            r_err_timeout <= 1'b0;
            if (w_fall) begin
                r_wd <= '0;
                case (r_state)
                    ST_IDLE: begin
                        if (!w_data) begin
                            r_state  <= ST_DATA;
                            r_bitcnt <= '0;
                        end else begin
                            r_err_frame <= 1'b1;
                            r_ext       <= 1'b0;
                            r_brk       <= 1'b0;
                        end
                    end
                    ST_DATA: begin
                        r_shift  <= {w_data, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 1'b1;
                        if (r_bitcnt == 3'd7) r_state <= ST_PARITY;
                    end
                    ST_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                        r_parity <= w_data;
`endif
                        r_state  <= ST_STOP;
                    end
                    ST_STOP: begin
                        r_state <= ST_IDLE;
                        if (w_frame_ok) begin
                            if (r_shift == PS2_EXT_PREFIX) begin
                                r_ext <= 1'b1;
                            end else if (r_shift == PS2_BRK_PREFIX) begin
                                r_brk <= 1'b1;
                            end else begin
                                r_push     <= 1'b1;
                                r_push_evt <= '{ext: r_ext, brk: r_brk, code: r_shift};
                                r_ext      <= 1'b0;
                                r_brk      <= 1'b0;
                            end
                        end else begin
                            r_err_frame <= 1'b1;
                            r_ext       <= 1'b0;
                            r_brk       <= 1'b0;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end else if (r_state == ST_IDLE) begin
                r_wd <= '0;
            end else if (r_wd == WDW'(TIMEOUT_CYCLES - 1)) begin
                r_state       <= ST_IDLE;
                r_wd          <= '0;
                r_err_timeout <= 1'b1;
                r_ext         <= 1'b0;
                r_brk         <= 1'b0;
            end else begin
                r_wd <= r_wd + 1'b1;
            end
        end
    end

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop   = !w_empty && key_ready;
    // A simultaneous pop frees the slot, so a push into a full FIFO is kept
    assign w_wr    = r_push && (!w_full || w_pop);

    // FIFO pointers and overflow pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_err_overflow <= 1'b0;
        end else begin
            r_err_overflow <= r_push && w_full && !w_pop;
            if (w_wr)  r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
        end
    end

    // FIFO storage; contents are masked at the outputs while empty
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr[AW-1:0]] <= r_push_evt;
    end

    assign w_head       = r_mem[r_rptr[AW-1:0]];
    assign key_valid    = !w_empty;
    assign key_code     = key_valid ? w_head.code : '0;
    assign key_ext      = key_valid & w_head.ext;
    assign key_release  = key_valid & w_head.brk;
    assign err_frame    = r_err_frame;
    assign err_timeout  = r_err_timeout;
    assign err_overflow = r_err_overflow;

endmodule

// File: tb/tb_ps2_keycode_receiver.sv
// tb_ps2_keycode_receiver: directed frames with hand-computed expectations.
// The PS/2 bit period is scaled down (80 clk cycles) to keep runs short.
module tb_ps2_keycode_receiver;

    localparam int FL   = 8;
    localparam int TO   = 500;
    localparam int FD   = 4;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_release;
    logic       key_valid;
    logic       key_ready = 1'b0;
    logic       err_frame;
    logic       err_timeout;
    logic       err_overflow;

    int n_vec = 0;
    int n_err = 0;
    int n_ferr = 0;
    int n_tout = 0;
    int n_ovf = 0;
    int lat;
    int f0, t0, o0;

    ps2_keycode_receiver #(
        .FILTER_LEN     (FL),
        .TIMEOUT_CYCLES (TO),
        .FIFO_DEPTH     (FD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .key_code     (key_code),
        .key_ext      (key_ext),
        .key_release  (key_release),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .err_frame    (err_frame),
        .err_timeout  (err_timeout),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    // Count one-cycle error pulses
    always @(posedge clk) begin
        if (err_frame)    n_ferr <= n_ferr + 1;
        if (err_timeout)  n_tout <= n_tout + 1;
        if (err_overflow) n_ovf  <= n_ovf + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Send the first npulse bits of a frame (11 = complete). lat returns the
    // number of negedges from the stop-bit fall to key_valid (0 = not seen).
    task automatic send_frame(input logic [7:0] b, input logic bad_par, input int npulse,
                              output int latency);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        latency = 0;
        for (int i = 0; i < npulse; i++) begin
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            for (int k = 1; k <= HALF; k++) begin
                @(negedge clk);
                if (i == 10 && latency == 0 && key_valid) latency = k;
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] code, input logic ext,
                              input logic rel);
        int waited;
        waited = 0;
        while (!key_valid && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, "_valid"}, key_valid, 1'b1);
        chk({tag, "_code"}, key_code, code);
        chk({tag, "_ext"}, key_ext, ext);
        chk({tag, "_rel"}, key_release, rel);
        key_ready = 1'b1;
        @(negedge clk);
        key_ready = 1'b0;
    endtask

    initial begin
        repeat (5) @(negedge clk);
        // Outputs while reset is held
        chk("rst_valid", key_valid, 1'b0);
        chk("rst_code", key_code, 8'h00);
        chk("rst_ext_rel", {key_ext, key_release}, 2'b00);
        chk("rst_errs", {err_frame, err_timeout, err_overflow}, 3'b000);
        rst = 1'b1;
        repeat (20) @(negedge clk);

        // Single frame 1C and push-to-valid latency
        send_frame(8'h1C, 1'b0, 11, lat);
        chk("lat_1C", lat, FL + 4);
        pop_expect("e_1C", 8'h1C, 1'b0, 1'b0);
        chk("empty_1C", key_valid, 1'b0);

        // E0 F0 75 folds into one entry, then 29
        send_frame(8'hE0, 1'b0, 11, lat);
        send_frame(8'hF0, 1'b0, 11, lat);
        chk("no_entry_prefix", key_valid, 1'b0);
        send_frame(8'h75, 1'b0, 11, lat);
        pop_expect("e_75", 8'h75, 1'b1, 1'b1);
        chk("empty_75", key_valid, 1'b0);
        send_frame(8'h29, 1'b0, 11, lat);
        pop_expect("e_29", 8'h29, 1'b0, 1'b0);

        // Frame 21 with wrong parity
        f0 = n_ferr;
        send_frame(8'h21, 1'b1, 11, lat);
`ifdef PS2_PARITY_CHECK_EN
        chk("par_err_cnt", n_ferr - f0, 1);
        chk("par_no_entry", key_valid, 1'b0);
`else
        chk("par_err_cnt", n_ferr - f0, 0);
        pop_expect("e_21np", 8'h21, 1'b0, 1'b0);
`endif

        // Watchdog: start + 5 data bits then silence
        t0 = n_tout;
        f0 = n_ferr;
        send_frame(8'h32, 1'b0, 6, lat);
        repeat (TO + 200) @(negedge clk);
        chk("tout_cnt", n_tout - t0, 1);
        chk("tout_no_ferr", n_ferr - f0, 0);
        chk("tout_no_entry", key_valid, 1'b0);
        send_frame(8'h32, 1'b0, 11, lat);
        pop_expect("e_32", 8'h32, 1'b0, 1'b0);

        // Overflow: five frames into a depth-4 FIFO
        o0 = n_ovf;
        send_frame(8'h1C, 1'b0, 11, lat);
        send_frame(8'h32, 1'b0, 11, lat);
        send_frame(8'h21, 1'b0, 11, lat);
        send_frame(8'h29, 1'b0, 11, lat);
        chk("ovf_none_yet", n_ovf - o0, 0);
        send_frame(8'h5A, 1'b0, 11, lat);
        chk("ovf_cnt", n_ovf - o0, 1);
        pop_expect("o_1C", 8'h1C, 1'b0, 1'b0);
        pop_expect("o_32", 8'h32, 1'b0, 1'b0);
        pop_expect("o_21", 8'h21, 1'b0, 1'b0);
        pop_expect("o_29", 8'h29, 1'b0, 1'b0);
        chk("ovf_empty", key_valid, 1'b0);

        // 2-cycle glitch on idle ps2_clk with data high must not act as a fall
        f0 = n_ferr;
        ps2_clk = 1'b0;
        repeat (2) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (100) @(negedge clk);
        chk("glitch_ferr", n_ferr - f0, 0);
        chk("glitch_valid", key_valid, 1'b0);

        // Reset mid-frame: no output, no errors, then clean reception
        f0 = n_ferr;
        t0 = n_tout;
        send_frame(8'h5A, 1'b0, 4, lat);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_valid", key_valid, 1'b0);
        rst = 1'b1;
        repeat (TO + 200) @(negedge clk);
        chk("midrst_errs", (n_ferr - f0) + (n_tout - t0), 0);
        chk("midrst_empty", key_valid, 1'b0);
        send_frame(8'h5A, 1'b0, 11, lat);
        pop_expect("e_5A", 8'h5A, 1'b0, 1'b0);
        chk("final_empty", key_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
